// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the data-memory access sequencer.
package mem_access_pkg;

  localparam int XLEN_DEFAULT = 64;

  // Access size as encoded on req_size.
  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  // Sequencer states.
  typedef enum logic [2:0] {
    IDLE,
    RD,
    WAIT,
    WR,
    RESP
  } state_e;

  // Number of bytes moved by an access of the given size.
  function automatic logic [3:0] sizeBytes(input size_e sz);
    return 4'd1 << sz;
  endfunction

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] lowMask(input size_e sz);
    logic [3:0] bytesMinusOne;
    bytesMinusOne = sizeBytes(sz) - 4'd1;
    return bytesMinusOne[2:0];
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response and data-memory bus of the access sequencer.
// master: the environment (control FSM plus memory); slave: the sequencer.
interface mem_access_unit_if
  import mem_access_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
);

  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  size_e           req_size;
  logic            req_unsigned;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;

  logic            rsp_valid;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_err;

  logic [XLEN-1:0] mem_addr;
  logic            mem_rd;
  logic            mem_wr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_rd, mem_wr, mem_wdata
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_rd, mem_wr, mem_wdata
  );

endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane handling for one dword: extracts and extends a load lane and
// merges store bytes into the dword for read-modify-write.
module mem_lane_align
  import mem_access_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] dword,
  input  logic [2:0]      offset,
  input  size_e           size,
  input  logic            isUnsigned,
  input  logic [XLEN-1:0] storeData,
  output logic [XLEN-1:0] loadData,
  output logic [XLEN-1:0] mergedData
);

  logic [5:0]      shamt;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] laneMask;
  logic [XLEN-1:0] placedMask;

  // Shift the addressed lane to bit 0, extend it, and build the store merge.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    shamt    = {offset, 3'b000};
    shifted  = dword >> shamt;
    loadData = shifted;
    laneMask = '1;
    case (size)
      SZ_B: begin
        loadData = {{(XLEN-8){~isUnsigned & shifted[7]}}, shifted[7:0]};
        laneMask = {{(XLEN-8){1'b0}}, 8'hFF};
      end
      SZ_H: begin
        loadData = {{(XLEN-16){~isUnsigned & shifted[15]}}, shifted[15:0]};
        laneMask = {{(XLEN-16){1'b0}}, 16'hFFFF};
      end
      SZ_W: begin
        loadData = {{(XLEN-32){~isUnsigned & shifted[31]}}, shifted[31:0]};
        laneMask = {{(XLEN-32){1'b0}}, 32'hFFFF_FFFF};
      end
      default: ; // full dword: offset is zero, nothing to extend or mask
    endcase
    placedMask = laneMask << shamt;
    mergedData = (dword & ~placedMask) | ((storeData << shamt) & placedMask);
  end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory access sequencer: one load or store at a time against a
// dword-wide memory without byte enables (sub-dword stores use
// read-modify-write). All outputs are registered.
// Optional build macro MEM_ACCESS_MISALIGN_TRAP_EN: misaligned requests
// respond immediately with rsp_err instead of truncating the offset.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int XLEN    = XLEN_DEFAULT,
  parameter int MEM_LAT = 1
) (
  input logic               clk,
  input logic               reset,
  mem_access_unit_if.slave  bus
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);

  state_e          state;
  logic [CNT_W-1:0] waitCnt;

  // Request latched at acceptance; req_* is ignored until back in IDLE.
  logic [XLEN-1:0] addrQ;
  size_e           sizeQ;
  logic            weQ;
  logic            unsQ;
  logic [XLEN-1:0] wdataQ;

  logic [2:0]      laneOff;
  logic            trapReq;
  logic [XLEN-1:0] loadData;
  logic [XLEN-1:0] mergedData;

  // Offset truncated to natural alignment; a no-op for aligned requests.
  assign laneOff = addrQ[2:0] & ~lowMask(sizeQ);

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  assign trapReq = |(bus.req_addr[2:0] & lowMask(bus.req_size));
`else
  assign trapReq = 1'b0;
`endif

  // Lane logic works on mem_rdata directly, so the read dword lands straight
  // in the rsp_rdata / mem_wdata registers on the capture edge.
  mem_lane_align #(.XLEN(XLEN)) u_align (
    .dword      (bus.mem_rdata),
    .offset     (laneOff),
    .size       (sizeQ),
    .isUnsigned (unsQ),
    .storeData  (wdataQ),
    .loadData   (loadData),
    .mergedData (mergedData)
  );

  // Sequencer FSM; outputs are set on the edge that enters each state.
  // NOTE: async reset is in the sensitivity list so strobes drop without waiting for a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      waitCnt       <= '0;
      addrQ         <= '0;
      sizeQ         <= SZ_B;
      weQ           <= 1'b0;
      unsQ          <= 1'b0;
      wdataQ        <= '0;
      bus.req_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_rd    <= 1'b0;
      bus.mem_wr    <= 1'b0;
      bus.mem_wdata <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout so every register updates from pre-edge values.
      bus.req_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_rd    <= 1'b0;
      bus.mem_wr    <= 1'b0;
      bus.mem_wdata <= '0;
      case (state)
        IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            addrQ  <= bus.req_addr;
            sizeQ  <= bus.req_size;
            weQ    <= bus.req_we;
            unsQ   <= bus.req_unsigned;
            wdataQ <= bus.req_wdata;
            if (trapReq) begin
              state         <= RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b1;
            end else if (bus.req_we && bus.req_size == SZ_D) begin
              state         <= WR;
              bus.mem_wr    <= 1'b1;
              bus.mem_addr  <= {bus.req_addr[XLEN-1:3], 3'b000};
              bus.mem_wdata <= bus.req_wdata;
            end else begin
              state        <= RD;
              bus.mem_rd   <= 1'b1;
              bus.mem_addr <= {bus.req_addr[XLEN-1:3], 3'b000};
            end
          end else begin
            bus.req_ready <= 1'b1;
          end
        end
        RD: begin
          waitCnt <= CNT_W'(MEM_LAT);
          state   <= WAIT;
        end
        WAIT: begin
          if (waitCnt == CNT_W'(1)) begin
            if (weQ) begin
              state         <= WR;
              bus.mem_wr    <= 1'b1;
              bus.mem_addr  <= {addrQ[XLEN-1:3], 3'b000};
              bus.mem_wdata <= mergedData;
            end else begin
              state         <= RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_rdata <= loadData;
            end
          end
          waitCnt <= waitCnt - CNT_W'(1);
        end
        WR: begin
          state         <= RESP;
          bus.rsp_valid <= 1'b1;
        end
        RESP: begin
          state         <= IDLE;
          bus.req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with MEM_LAT=1.
module tb_mem_access_unit;
  import mem_access_pkg::*;

  localparam int XLEN = 64;
  localparam logic [63:0] ORIG = 64'h8877_6655_4433_2211;

  logic clk = 1'b0;
  logic reset = 1'b1;

  int vectors = 0;
  int miscompares = 0;

  mem_access_unit_if #(.XLEN(XLEN)) bus ();

  mem_access_unit #(.XLEN(XLEN), .MEM_LAT(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Dword memory model, read data valid one cycle after the mem_rd cycle.
  logic [63:0] memArr [0:63];
  always @(posedge clk) begin
    if (bus.mem_wr) memArr[bus.mem_addr[8:3]] <= bus.mem_wdata;
    if (bus.mem_rd) bus.mem_rdata <= memArr[bus.mem_addr[8:3]];
  end

  // Observations of one request, cycles counted from the accept cycle.
  int rdCnt, wrCnt, rspCnt, bothCnt, rdCyc, wrCyc, rspCyc;
  logic [63:0] rdAddr, wrAddr, wrData, rspData;
  logic rspErr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  // Issue one request and watch a fixed 8-cycle window.
  task automatic runReq(input logic we, input size_e size, input logic uns,
                        input logic [63:0] addr, input logic [63:0] wdata);
    rdCnt = 0; wrCnt = 0; rspCnt = 0; bothCnt = 0;
    rdCyc = -1; wrCyc = -1; rspCyc = -1;
    rdAddr = '0; wrAddr = '0; wrData = '0; rspData = '0; rspErr = 1'b0;
    @(negedge clk);
    check("req_ready before accept", 64'(bus.req_ready), 64'd1);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = size;
    bus.req_unsigned = uns; bus.req_addr = addr; bus.req_wdata = wdata;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (bus.mem_rd) begin rdCnt++; rdCyc = k; rdAddr = bus.mem_addr; end
      if (bus.mem_wr) begin wrCnt++; wrCyc = k; wrAddr = bus.mem_addr; wrData = bus.mem_wdata; end
      if (bus.mem_rd && bus.mem_wr) bothCnt++;
      if (bus.rsp_valid) begin rspCnt++; rspCyc = k; rspData = bus.rsp_rdata; rspErr = bus.rsp_err; end
      if (k == 1) begin
        // Scramble inputs while busy: the latched request must be used.
        bus.req_valid = 1'b0; bus.req_we = ~we; bus.req_size = SZ_D;
        bus.req_unsigned = ~uns; bus.req_addr = '1; bus.req_wdata = '1;
      end
    end
  endtask

  task automatic checkLoad(input string tag, input int cyc, input logic [63:0] exp);
    check({tag, " rsp cycle"}, 64'(rspCyc), 64'(cyc));
    check({tag, " rsp count"}, 64'(rspCnt), 64'd1);
    check({tag, " rdata"}, rspData, exp);
    check({tag, " err"}, 64'(rspErr), 64'd0);
    check({tag, " mem_rd count"}, 64'(rdCnt), 64'd1);
    check({tag, " mem_wr count"}, 64'(wrCnt), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) memArr[i] = '0;
    memArr[6'h20] = ORIG;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = SZ_B;
    bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;

    // Reset state.
    @(negedge clk);
    check("reset req_ready", 64'(bus.req_ready), 64'd0);
    check("reset rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("reset mem_rd", 64'(bus.mem_rd), 64'd0);
    check("reset mem_wr", 64'(bus.mem_wr), 64'd0);
    check("reset mem_addr", bus.mem_addr, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("req_ready after reset", 64'(bus.req_ready), 64'd1);

    // 1. LB signed at top byte.
    runReq(1'b0, SZ_B, 1'b0, 64'h107, 64'd0);
    checkLoad("lb 0x107", 3, 64'hFFFF_FFFF_FFFF_FF88);
    check("lb 0x107 mem_rd cycle", 64'(rdCyc), 64'd1);
    check("lb 0x107 mem_addr", rdAddr, 64'h100);

    // LBU at same byte.
    runReq(1'b0, SZ_B, 1'b1, 64'h107, 64'd0);
    checkLoad("lbu 0x107", 3, 64'h0000_0000_0000_0088);

    // 2. LHU / LH at 0x102.
    runReq(1'b0, SZ_H, 1'b1, 64'h102, 64'd0);
    checkLoad("lhu 0x102", 3, 64'h0000_0000_0000_4433);
    runReq(1'b0, SZ_H, 1'b0, 64'h102, 64'd0);
    checkLoad("lh 0x102", 3, 64'h0000_0000_0000_4433);

    // LW at 0x104: negative word.
    runReq(1'b0, SZ_W, 1'b0, 64'h104, 64'd0);
    checkLoad("lw 0x104", 3, 64'hFFFF_FFFF_8877_6655);

    // 5. Misaligned LW at 0x102.
    runReq(1'b0, SZ_W, 1'b0, 64'h102, 64'd0);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    check("lw misaligned rsp cycle", 64'(rspCyc), 64'd1);
    check("lw misaligned err", 64'(rspErr), 64'd1);
    check("lw misaligned rdata", rspData, 64'd0);
    check("lw misaligned mem_rd count", 64'(rdCnt), 64'd0);
    check("lw misaligned mem_wr count", 64'(wrCnt), 64'd0);
`else
    checkLoad("lw misaligned", 3, 64'h0000_0000_4433_2211);
`endif

    // 6. SH at 0x104 with reset pulsed during WAIT.
    @(negedge clk);
    check("sh reset req_ready", 64'(bus.req_ready), 64'd1);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = SZ_H;
    bus.req_unsigned = 1'b0; bus.req_addr = 64'h104; bus.req_wdata = 64'hBEEF;
    @(negedge clk);
    check("sh reset mem_rd in RD", 64'(bus.mem_rd), 64'd1);
    bus.req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("async reset mem_wr", 64'(bus.mem_wr), 64'd0);
    check("async reset mem_rd", 64'(bus.mem_rd), 64'd0);
    check("async reset rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("async reset req_ready", 64'(bus.req_ready), 64'd0);
    check("async reset mem_addr", bus.mem_addr, 64'd0);
    check("async reset mem_wdata", bus.mem_wdata, 64'd0);
    wrCnt = 0;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (bus.mem_wr) wrCnt++;
    end
    check("no mem_wr after reset", 64'(wrCnt), 64'd0);
    check("req_ready after release", 64'(bus.req_ready), 64'd1);
    runReq(1'b0, SZ_D, 1'b0, 64'h100, 64'd0);
    checkLoad("ld after reset", 3, ORIG);

    // 3. SB at 0x101 (upper wdata bytes must be ignored).
    runReq(1'b1, SZ_B, 1'b0, 64'h101, 64'hFFFF_FFFF_FFFF_FFAB);
    check("sb mem_rd cycle", 64'(rdCyc), 64'd1);
    check("sb mem_rd count", 64'(rdCnt), 64'd1);
    check("sb mem_wr cycle", 64'(wrCyc), 64'd3);
    check("sb mem_wr count", 64'(wrCnt), 64'd1);
    check("sb mem_addr", wrAddr, 64'h100);
    check("sb mem_wdata", wrData, 64'h8877_6655_4433_AB11);
    check("sb rsp cycle", 64'(rspCyc), 64'd4);
    check("sb rdata", rspData, 64'd0);
    check("sb rd/wr overlap", 64'(bothCnt), 64'd0);
    runReq(1'b0, SZ_D, 1'b1, 64'h100, 64'd0);
    checkLoad("ld after sb", 3, 64'h8877_6655_4433_AB11);

    // 4. SD at 0x100.
    runReq(1'b1, SZ_D, 1'b0, 64'h100, 64'h0123_4567_89AB_CDEF);
    check("sd mem_rd count", 64'(rdCnt), 64'd0);
    check("sd mem_wr cycle", 64'(wrCyc), 64'd1);
    check("sd mem_wr count", 64'(wrCnt), 64'd1);
    check("sd mem_wdata", wrData, 64'h0123_4567_89AB_CDEF);
    check("sd rsp cycle", 64'(rspCyc), 64'd2);

    // Loads of the SD result.
    runReq(1'b0, SZ_H, 1'b0, 64'h100, 64'd0);
    checkLoad("lh after sd", 3, 64'hFFFF_FFFF_FFFF_CDEF);
    runReq(1'b0, SZ_W, 1'b1, 64'h104, 64'd0);
    checkLoad("lwu after sd", 3, 64'h0000_0000_0123_4567);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
